mac_burst_arbiter: RTL and testbench
====================================

Name: mac_burst_arbiter

Overview:
- Shares one MAC datapath (multiplier + accumulator) between NREQ requesters.
- Each requester submits a burst of operand pairs; the burst ends with the pair flagged last. The block returns the accumulated dot product for that burst.
- Sequences the datapath strobes (clear, load A/B, start multiply, load accumulator, start adder) and waits on the multiplier's valid flag.
- Sits between requesting engines and the MAC datapath, and replaces the single-user MAC controller.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DW, 8, operand and sum width
- TIMEOUT, 16, maximum cycles to wait for dp_valid_mul before aborting the burst

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operand pair valid
- req_ready  out  NREQ  per-requester operand pair accepted
- req_a  in  NREQ*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing as req_a
- req_last  in  NREQ  current pair is the final pair of the burst
- resp_valid  out  1  burst result available
- resp_ready  in  1  result consumed
- resp_sum  out  DW  accumulated result
- resp_id  out  $clog2(NREQ)  requester that owns the result
- resp_err  out  1  burst aborted by multiplier timeout
- busy  out  1  a burst is in progress (state other than IDLE)
- dp_clr  out  1  pulse: clear multiplier and accumulator
- dp_a  out  DW  operand A to datapath
- dp_b  out  DW  operand B to datapath
- dp_ldA  out  1  load A strobe
- dp_ldB  out  1  load B strobe
- dp_start_mul  out  1  start multiplier strobe
- dp_valid_mul  in  1  multiplier product valid
- dp_ldacc  out  1  load accumulator strobe
- dp_start_adder  out  1  start adder strobe
- dp_sum  in  DW  accumulator output

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - last_grant = NREQ-1, so requester 0 has highest priority first.
  - Reset mid-burst drops the burst with no response and no dp_clr.
- All strobes are single-cycle registered pulses.
- States: IDLE, CLR, LOAD, LD, MUL, WAIT, ACC, POST, RESP.
- IDLE:
  - If any req_valid is set, grant g = first valid requester searching from last_grant+1 (mod NREQ).
  - Latch g, then go to CLR.
- CLR: dp_clr=1 for one cycle, then LOAD.
- LOAD:
  - req_ready[g] = 1; all other req_ready bits are 0.
  - On req_valid[g] & req_ready[g]: capture a, b and last into registers, then go to LD.
  - If req_valid[g] is low, wait with no timeout; the grant is held.
- LD: dp_a/dp_b drive the captured operands (held stable until the next capture); dp_ldA = dp_ldB = 1.
- MUL: dp_start_mul = 1, then WAIT.
- WAIT:
  - Counter starts at 0 and increments each cycle.
  - dp_valid_mul = 1 goes to ACC.
  - If the counter reaches TIMEOUT with no valid: resp_err = 1, resp_sum = 0, go to RESP.
- ACC: dp_ldacc = dp_start_adder = 1.
- POST (one settle cycle):
  - If last is set: resp_sum <= dp_sum, go to RESP.
  - Otherwise go to LOAD.
- RESP:
  - resp_valid = 1, with resp_sum, resp_id = g and resp_err held stable until resp_ready.
  - On the handshake: last_grant = g, clear resp_err, go to IDLE.
  - No new grant is issued while in RESP.
- Latency: from pair acceptance to ACC = 3 cycles + multiplier latency.
- Arithmetic is the datapath's (modulo 2^DW); this block does no arithmetic.
- Simultaneous events:
  - dp_valid_mul in the same cycle the counter reaches TIMEOUT: valid wins.
  - Requests arriving during a burst wait for IDLE.

Test Plan:
- Single pair (17, 5, last) from req0, multiplier latency 4 -> dp_clr, ldA/ldB, start_mul, ACC; resp_sum = 85, resp_id = 0, resp_err = 0.
- Burst from req0: (17,5), (11,12), (14,9 last) with an accumulating datapath -> resp_sum = 343 mod 256 = 87 (0x57); req_ready asserted exactly 3 handshakes.
- req0 and req1 each continuously issue 1-pair bursts -> grant order 0,1,0,1; the ungranted req_ready stays 0 throughout.
- dp_valid_mul held low with TIMEOUT = 16 -> RESP entered after 16 WAIT cycles with resp_err = 1, resp_sum = 0; the next burst proceeds normally.
- resp_ready held low 5 cycles while req1 is valid -> resp_valid, resp_sum and resp_id stay stable; req1 is granted only after the handshake.
- rst pulsed during WAIT -> next cycle all outputs 0, state IDLE, no response; the following req0 burst is granted first.

Source files
------------

// File: rtl/mac_burst_arbiter.sv
// Round-robin arbiter that shares one MAC datapath between NREQ requesters.
// It sequences the datapath strobes for each operand pair and returns the dot product of a burst.
module mac_burst_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DW-1:0]      req_a,
  input  logic [NREQ*DW-1:0]      req_b,
  input  logic [NREQ-1:0]         req_last,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DW-1:0]           resp_sum,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    dp_clr,
  output logic [DW-1:0]           dp_a,
  output logic [DW-1:0]           dp_b,
  output logic                    dp_ldA,
  output logic                    dp_ldB,
  output logic                    dp_start_mul,
  input  logic                    dp_valid_mul,
  output logic                    dp_ldacc,
  output logic                    dp_start_adder,
  input  logic [DW-1:0]           dp_sum
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, CLR, LOAD, LD, MUL, WAIT, ACC, POST, RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            err_q, err_d;
  logic            resp_valid_q, resp_valid_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            clr_q, clr_d;
  logic            ld_q, ld_d;
  logic            mul_q, mul_d;
  logic            acc_q, acc_d;

  logic            sel_valid;
  logic            sel_last;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;

  // First valid requester strictly after 'last', wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last) + k) % NREQ);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_a     = req_a[i*DW +: DW];
        sel_b     = req_b[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    id_d         = id_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = rr_pick(req_valid, last_grant_q);
          state_d = CLR;
        end
      end
      CLR:  state_d = LOAD;
      LOAD: begin
        if (sel_valid && req_ready_q[grant_q]) begin
          a_d     = sel_a;
          b_d     = sel_b;
          last_d  = sel_last;
          state_d = LD;
        end
      end
      LD:   state_d = MUL;
      MUL: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (dp_valid_mul) begin
          state_d = ACC;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          sum_d   = '0;
          id_d    = grant_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACC:  state_d = POST;
      POST: begin
        if (last_q) begin
          sum_d   = dp_sum;
          id_d    = grant_q;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          state_d = LOAD;
        end
      end
      RESP: begin
        if (resp_ready) begin
          last_grant_d = grant_q;
          err_d        = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so each is high exactly while in its state.
    resp_valid_d = (state_d == RESP);
    req_ready_d  = (state_d == LOAD) ? (NREQ'(1) << grant_d) : '0;
    clr_d        = (state_d == CLR);
    ld_d         = (state_d == LD);
    mul_d        = (state_d == MUL);
    acc_d        = (state_d == ACC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      sum_q        <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= '0;
      clr_q        <= 1'b0;
      ld_q         <= 1'b0;
      mul_q        <= 1'b0;
      acc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      id_q         <= id_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      clr_q        <= clr_d;
      ld_q         <= ld_d;
      mul_q        <= mul_d;
      acc_q        <= acc_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_sum       = sum_q;
  assign resp_id        = id_q;
  assign resp_err       = err_q;
  assign busy           = (state_q != IDLE);
  assign dp_clr         = clr_q;
  assign dp_a           = a_q;
  assign dp_b           = b_q;
  assign dp_ldA         = ld_q;
  assign dp_ldB         = ld_q;
  assign dp_start_mul   = mul_q;
  assign dp_ldacc       = acc_q;
  assign dp_start_adder = acc_q;

endmodule

// File: tb/tb_mac_burst_arbiter.sv
// Directed bench for mac_burst_arbiter with a small multiplier/accumulator datapath model.
module tb_mac_burst_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned DW      = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned LAT     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]   req_last;
  logic              resp_valid;
  logic              resp_ready;
  logic [DW-1:0]     resp_sum;
  logic [0:0]        resp_id;
  logic              resp_err;
  logic              busy;
  logic              dp_clr;
  logic [DW-1:0]     dp_a;
  logic [DW-1:0]     dp_b;
  logic              dp_ldA;
  logic              dp_ldB;
  logic              dp_start_mul;
  logic              dp_valid_mul;
  logic              dp_ldacc;
  logic              dp_start_adder;
  logic [DW-1:0]     dp_sum;

  int checks   = 0;
  int failures = 0;

  mac_burst_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_last(req_last),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_id(resp_id), .resp_err(resp_err),
    .busy(busy),
    .dp_clr(dp_clr), .dp_a(dp_a), .dp_b(dp_b),
    .dp_ldA(dp_ldA), .dp_ldB(dp_ldB),
    .dp_start_mul(dp_start_mul), .dp_valid_mul(dp_valid_mul),
    .dp_ldacc(dp_ldacc), .dp_start_adder(dp_start_adder),
    .dp_sum(dp_sum)
  );

  always #5 clk = ~clk;

  // Datapath model: product valid LAT edges after start_mul is sampled.
  logic [DW-1:0] ra, rb, prod, acc;
  logic [3:0]    mcnt;
  logic          mul_en;
  always @(posedge clk) begin
    if (rst) begin
      ra <= '0; rb <= '0; prod <= '0; acc <= '0; mcnt <= '0;
    end else begin
      if (dp_ldA) ra <= dp_a;
      if (dp_ldB) rb <= dp_b;
      if (dp_start_mul) begin
        prod <= DW'(ra * rb);
        mcnt <= 4'(LAT);
      end else if (mcnt != 4'd0) begin
        mcnt <= mcnt - 4'd1;
      end
      if (dp_clr) acc <= '0;
      else if (dp_ldacc) acc <= DW'(acc + prod);
    end
  end
  assign dp_valid_mul = mul_en && (mcnt == 4'd1);
  assign dp_sum       = acc;

  int unsigned hs0 = 0;
  always @(posedge clk) if (!rst && req_valid[0] && req_ready[0]) hs0 <= hs0 + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  32'(req_ready), 32'd0);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_sum"},    32'(resp_sum), 32'd0);
    chk({tag, "_id"},     32'(resp_id), 32'd0);
    chk({tag, "_err"},    32'(resp_err), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_strb"},   32'({dp_clr, dp_ldA, dp_ldB, dp_start_mul, dp_ldacc, dp_start_adder}), 32'd0);
    chk({tag, "_dpab"},   32'({dp_a, dp_b}), 32'd0);
  endtask

  task automatic push(input int unsigned idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic last);
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
    req_last[idx]       = last;
    req_valid[idx]      = 1'b1;
    for (int i = 0; i < 60 && !req_ready[idx]; i++) @(negedge clk);
    chk("accept", 32'(req_ready[idx]), 32'd1);
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    for (int i = 0; i < 80 && !resp_valid; i++) @(negedge clk);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20 && !dp_start_mul; i++) @(negedge clk);
    chk({tag, "_start_mul"}, 32'(dp_start_mul), 32'd1);
  endtask

  initial begin
    int unsigned base;
    int          n;
    logic [1:0]  exp_oh;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_last = '0;
    resp_ready = 1'b1; mul_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single pair 17*5 from req0, cycle by cycle.
    req_a[7:0] = 8'd17; req_b[7:0] = 8'd5; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t1_clr", 32'(dp_clr), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_in_clr", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("t1_clr_pulse", 32'(dp_clr), 32'd0);
    chk("t1_ready_load", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("t1_ready_drop", 32'(req_ready), 32'd0);
    chk("t1_ldab", 32'({dp_ldA, dp_ldB}), 32'd3);
    chk("t1_dpa", 32'(dp_a), 32'd17);
    chk("t1_dpb", 32'(dp_b), 32'd5);
    @(negedge clk);
    chk("t1_start_mul", 32'(dp_start_mul), 32'd1);
    chk("t1_ld_pulse", 32'({dp_ldA, dp_ldB}), 32'd0);
    chk("t1_dpa_hold", 32'(dp_a), 32'd17);
    @(negedge clk);
    chk("t1_mul_pulse", 32'(dp_start_mul), 32'd0);
    n = 0;
    while (n < 30 && !dp_ldacc) begin
      @(negedge clk);
      n++;
    end
    chk("t1_acc_latency", 32'(n), 32'(LAT));
    chk("t1_ldacc_adder", 32'({dp_ldacc, dp_start_adder}), 32'd3);
    wait_resp("t1");
    chk("t1_sum", 32'(resp_sum), 32'd85);
    chk("t1_id", 32'(resp_id), 32'd0);
    chk("t1_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    chk("t1_resp_done", 32'(resp_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Three-pair burst from req0: 85+132+126 = 343 -> 87 modulo 256.
    base = hs0;
    push(0, 8'd17, 8'd5, 1'b0);
    push(0, 8'd11, 8'd12, 1'b0);
    push(0, 8'd14, 8'd9, 1'b1);
    wait_resp("t2");
    chk("t2_sum", 32'(resp_sum), 32'h57);
    chk("t2_id", 32'(resp_id), 32'd0);
    chk("t2_err", 32'(resp_err), 32'd0);
    chk("t2_handshakes", 32'(hs0 - base), 32'd3);
    @(negedge clk);

    // Fresh reset, then both requesters stream 1-pair bursts: grants alternate 0,1,0,1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_a = {8'd2, 8'd3}; req_b = {8'd5, 8'd4}; req_last = 2'b11; req_valid = 2'b11;
    for (int r = 0; r < 4; r++) begin
      exp_oh = (r % 2 == 0) ? 2'b01 : 2'b10;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (resp_valid) break;
        chk("t3_ungranted_ready", 32'(req_ready & ~exp_oh), 32'd0);
      end
      if (r == 3) req_valid = 2'b00;
      chk("t3_resp_valid", 32'(resp_valid), 32'd1);
      chk("t3_id", 32'(resp_id), 32'(r % 2));
      chk("t3_sum", 32'(resp_sum), (r % 2 == 0) ? 32'd12 : 32'd10);
    end
    @(negedge clk);

    // Multiplier never answers: 16 WAIT cycles, then error response from req1.
    mul_en = 1'b0;
    push(1, 8'd3, 8'd3, 1'b1);
    wait_start("t4");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    chk("t4_wait_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("t4_err", 32'(resp_err), 32'd1);
    chk("t4_sum", 32'(resp_sum), 32'd0);
    chk("t4_id", 32'(resp_id), 32'd1);
    @(negedge clk);
    chk("t4_err_cleared", 32'(resp_err), 32'd0);
    mul_en = 1'b1;
    push(0, 8'd6, 8'd7, 1'b1);
    wait_resp("t4b");
    chk("t4b_sum", 32'(resp_sum), 32'd42);
    chk("t4b_err", 32'(resp_err), 32'd0);
    chk("t4b_id", 32'(resp_id), 32'd0);
    @(negedge clk);

    // Response back-pressure: result stable, req1 waits for the handshake.
    resp_ready = 1'b0;
    push(0, 8'd9, 8'd9, 1'b1);
    wait_resp("t5");
    req_a[15:8] = 8'd2; req_b[15:8] = 8'd3; req_last[1] = 1'b1; req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold_valid", 32'(resp_valid), 32'd1);
      chk("t5_hold_sum", 32'(resp_sum), 32'd81);
      chk("t5_hold_id", 32'(resp_id), 32'd0);
      chk("t5_no_grant", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t5_released", 32'(resp_valid), 32'd0);
    for (int i = 0; i < 20 && req_ready == 2'b00; i++) @(negedge clk);
    chk("t5_req1_grant", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_resp("t5b");
    chk("t5b_sum", 32'(resp_sum), 32'd6);
    chk("t5b_id", 32'(resp_id), 32'd1);
    @(negedge clk);

    // Reset during WAIT after a req0 grant; req0 must still win the next tie.
    push(0, 8'd1, 8'd1, 1'b1);
    wait_resp("t6a");
    @(negedge clk);
    mul_en = 1'b0;
    push(0, 8'd4, 8'd4, 1'b1);
    wait_start("t6");
    repeat (3) @(negedge clk);
    chk("t6_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("t6_rst");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_resp", 32'({resp_valid, busy, dp_clr}), 32'd0);
    end
    mul_en = 1'b1;
    req_a = {8'd7, 8'd5}; req_b = {8'd7, 8'd5}; req_last = 2'b11; req_valid = 2'b11;
    for (int i = 0; i < 20 && req_ready == 2'b00; i++) @(negedge clk);
    chk("t6_first_grant", 32'(req_ready), 32'd1);
    wait_resp("t6b");
    req_valid = 2'b00;
    chk("t6b_id", 32'(resp_id), 32'd0);
    chk("t6b_sum", 32'(resp_sum), 32'd25);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
